// File: rtl/ram_stream_pkg.sv
// Shared types and helpers for the RAM stream reader.
//   state_e  : burst sequencer states
//   wrap_inc : address increment that wraps at an arbitrary depth
package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  // Next address modulo depth; depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
    return (addr + 32'd1 >= depth) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_2_entry.sv
// Two-entry synchronous FIFO with registered head outputs.
//   clk_i, reset_ni : clock, async active-low reset
//   push_i, data_i  : write strobe and entry (must not push when full without a pop)
//   pop_i           : consume the head (only while valid_o)
//   valid_o, data_o : head entry
//   count_o         : occupancy 0..2
module fifo_2_entry #(
  parameter int unsigned width_p = 9
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] head_q;
  logic [width_p-1:0] tail_q;
  logic [1:0]         count_q;

  // Head always holds the oldest entry so the outputs come straight from flops.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) head_q <= data_i;
          else                 tail_q <= data_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader for a 1-cycle-latency synchronous RAM, presenting words as a
// ready/valid stream with a last marker.
//   cmd_*   : burst command (start address, word count; 0 = empty burst)
//   rd_*    : RAM read port; rd_data_i is valid the cycle after a read edge
//   valid_o, data_o, last_o, ready_i : output stream
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned depth_p = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [$clog2(depth_p)-1:0]   cmd_addr_i,
  input  logic [$clog2(depth_p):0]     cmd_len_i,
  output logic                         rd_valid_o,
  output logic [$clog2(depth_p)-1:0]   rd_addr_o,
  input  logic [width_p-1:0]           rd_data_i,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  output logic                         last_o,
  input  logic                         ready_i
);

  localparam int unsigned addr_w  = $clog2(depth_p);
  localparam int unsigned len_w   = addr_w + 1;
  localparam int unsigned entry_w = width_p + 1;

  state_e              state_q;
  logic [addr_w-1:0]   addr_q;
  logic [len_w-1:0]    remain_q;
  logic                inflight_q;
  logic                last_pend_q;
  logic                cmd_ready_q;

  logic [1:0]          count;
  logic                fifo_valid;
  logic [entry_w-1:0]  head;
  logic                pop;
  logic                issue;
  logic [1:0]          load;

  assign pop = fifo_valid & ready_i;

  // Issue only if the word still fits once everything already headed for the
  // FIFO has landed, crediting this cycle's pop; never while both slots are full.
  always_comb begin
    load  = 2'd0;
    issue = 1'b0;
    load  = count + 2'(inflight_q) - 2'(pop);
    issue = (state_q == ISSUE) && (count != 2'd2) && (load < 2'd2);
  end

  // Burst sequencer, address/remaining counters and read-latency tracking.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      last_pend_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) last_pend_q <= (remain_q == len_w'(1));
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q && (cmd_len_i != '0)) begin
            addr_q      <= cmd_addr_i;
            remain_q    <= cmd_len_i;
            state_q     <= ISSUE;
            cmd_ready_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q   <= addr_w'(wrap_inc(32'(addr_q), depth_p));
            remain_q <= remain_q - len_w'(1);
            if (remain_q == len_w'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as the final word transfers so cmd_ready rises right after it.
          if (!inflight_q && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo_2_entry #(
    .width_p (entry_w)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (inflight_q),
    .data_i   ({last_pend_q, rd_data_i}),
    .pop_i    (pop),
    .valid_o  (fifo_valid),
    .data_o   (head),
    .count_o  (count)
  );

  assign cmd_ready_o = cmd_ready_q;
  assign rd_valid_o  = issue;
  assign rd_addr_o   = addr_q;
  assign valid_o     = fifo_valid;
  assign data_o      = head[width_p-1:0];
  assign last_o      = head[width_p];

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid, cmd_ready;
  logic [4:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       rd_valid;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       valid, last, ready;
  logic [7:0] data;

  logic       cmd_valid20, cmd_ready20;
  logic [4:0] cmd_addr20;
  logic [5:0] cmd_len20;
  logic       rd_valid20;
  logic [4:0] rd_addr20;
  logic [7:0] rd_data20;
  logic       valid20, last20, ready20;
  logic [7:0] data20;

  logic [7:0] mem   [32];
  logic [7:0] mem20 [20];

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q   [$];
  logic [7:0] got_log [$];
  time        got_t   [$];
  logic [4:0] rd_log  [$];
  logic [4:0] rd20_log[$];
  logic [7:0] out20_log[$];

  bit bp_mode = 0;
  int bp_cnt  = 0;

  typedef struct {
    logic [4:0] addr;
    logic [5:0] len;
    bit         bp;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } row_t;
  row_t rows[5];

  ram_stream_reader #(.width_p(8), .depth_p(32)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .rd_valid_o(rd_valid), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .valid_o(valid), .data_o(data), .last_o(last), .ready_i(ready)
  );

  ram_stream_reader #(.width_p(8), .depth_p(20)) dut20 (
    .clk_i(clk), .reset_ni(reset_n),
    .cmd_valid_i(cmd_valid20), .cmd_ready_o(cmd_ready20),
    .cmd_addr_i(cmd_addr20), .cmd_len_i(cmd_len20),
    .rd_valid_o(rd_valid20), .rd_addr_o(rd_addr20), .rd_data_i(rd_data20),
    .valid_o(valid20), .data_o(data20), .last_o(last20), .ready_i(ready20)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM models: data appears after the edge that samples the read.
  always @(posedge clk) if (rd_valid) rd_data <= mem[rd_addr];
  always @(posedge clk) if (rd_valid20) rd_data20 <= mem20[rd_addr20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] word_at(input int a);
    return 8'(a + 16);
  endfunction

  // Output monitor and scoreboard for the depth-32 instance.
  int         landed = 0, pend = 0, xfers = 0, held;
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [8:0] e;
  always @(negedge clk) begin
    if (!reset_n) begin
      landed = 0; pend = 0; xfers = 0; prev_stall = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {22'd0, valid, last, data}, {22'd0, 1'b1, prev_last, prev_data});
      held = landed - xfers;
      if (rd_valid) begin
        chk("issue_while_full", 32'(held == 2), 32'd0);
        rd_log.push_back(rd_addr);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word got=%0h exp=none @%0t", data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("word", {23'd0, last, data}, {23'd0, e});
        end
        got_log.push_back(data);
        got_t.push_back($time);
        xfers++;
      end
      landed += pend;
      pend = int'(rd_valid);
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_last  = last;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_valid20) rd20_log.push_back(rd_addr20);
      if (valid20 && ready20) out20_log.push_back(data20);
    end
  end

  // Downstream ready: 1,0,0 repeating while backpressure is enabled.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        ready = (bp_cnt % 3 == 0);
        bp_cnt++;
      end else begin
        ready = 1'b1;
      end
    end
  end

  task automatic send_cmd(input logic [4:0] a, input logic [5:0] l, output time acc_t);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("cmd_accept_timeout", 32'd0, 32'd1);
    acc_t = $time;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_row(input row_t r);
    time acc_t;
    int  l, n;
    l = int'(r.len);
    got_log.delete(); got_t.delete(); rd_log.delete();
    for (int i = 0; i < l; i++)
      exp_q.push_back({1'(i == l - 1), word_at((int'(r.addr) + i) % 32)});
    bp_cnt  = 0;
    bp_mode = r.bp;
    send_cmd(r.addr, r.len, acc_t);
    n = 0;
    while (!(got_log.size() >= l && cmd_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("burst_done_timeout", 32'd0, 32'd1);
    bp_mode = 0;
    chk("out_count", 32'(got_log.size()), 32'(l));
    chk("rd_count", 32'(rd_log.size()), 32'(l));
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    if (got_log.size() > 0) begin
      chk("first_word", 32'(got_log[0]), 32'(r.exp_first));
      chk("last_word", 32'(got_log[$]), 32'(r.exp_last));
      if (!r.bp) begin
        chk("first_valid_time", 32'(got_t[0] - acc_t), 32'd30);
        chk("last_valid_time", 32'(got_t[$] - acc_t), 32'((l + 2) * 10));
      end
    end
    for (int i = 0; i < rd_log.size() && i < l; i++)
      chk("rd_addr", 32'(rd_log[i]), 32'((int'(r.addr) + i) % 32));
    exp_q.delete();
  endtask

  initial begin
    time t;
    int  n;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 16);
    for (int i = 0; i < 20; i++) mem20[i] = 8'(i + 16);
    rows[0] = '{addr: 5'd7,  len: 6'd1,  bp: 1'b0, exp_first: 8'h17, exp_last: 8'h17};
    rows[1] = '{addr: 5'd4,  len: 6'd3,  bp: 1'b0, exp_first: 8'h14, exp_last: 8'h16};
    rows[2] = '{addr: 5'd30, len: 6'd4,  bp: 1'b0, exp_first: 8'h2E, exp_last: 8'h11};
    rows[3] = '{addr: 5'd0,  len: 6'd8,  bp: 1'b1, exp_first: 8'h10, exp_last: 8'h17};
    rows[4] = '{addr: 5'd31, len: 6'd33, bp: 1'b0, exp_first: 8'h2F, exp_last: 8'h2F};

    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_valid20 = 1'b0; cmd_addr20 = '0; cmd_len20 = '0; ready20 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Empty burst: accepted, but nothing is read or emitted.
    rd_log.delete();
    send_cmd(5'd3, 6'd0, t);
    repeat (4) begin
      @(negedge clk);
      chk("empty_rd_valid", 32'(rd_valid), 32'd0);
      chk("empty_valid", 32'(valid), 32'd0);
      chk("empty_cmd_ready", 32'(cmd_ready), 32'd1);
    end

    foreach (rows[i]) run_row(rows[i]);

    // Reset asserted mid-cycle while the third word of an 8-word burst is out.
    got_log.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'(i == 7), word_at(i)});
    send_cmd(5'd0, 6'd8, t);
    n = 0;
    while (got_log.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("mid_rst_wait_timeout", 32'd0, 32'd1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_last", 32'(last), 32'd0);
    chk("mid_rst_data", 32'(data), 32'd0);
    #3;
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (5) begin
      chk("post_rst_valid", 32'(valid), 32'd0);
      chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
      @(negedge clk);
    end
    run_row(rows[1]);

    // Non-power-of-two depth: 18, 19, then wrap to 0.
    rd20_log.delete(); out20_log.delete();
    @(posedge clk); #1;
    cmd_valid20 = 1'b1; cmd_addr20 = 5'd18; cmd_len20 = 6'd3;
    n = 0;
    @(negedge clk);
    while (!cmd_ready20 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("d20_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid20 = 1'b0;
    repeat (10) @(negedge clk);
    chk("d20_rd_count", 32'(rd20_log.size()), 32'd3);
    chk("d20_out_count", 32'(out20_log.size()), 32'd3);
    if (rd20_log.size() == 3) begin
      chk("d20_rd_addr0", 32'(rd20_log[0]), 32'd18);
      chk("d20_rd_addr1", 32'(rd20_log[1]), 32'd19);
      chk("d20_rd_addr2", 32'(rd20_log[2]), 32'd0);
    end
    if (out20_log.size() == 3) begin
      chk("d20_word0", 32'(out20_log[0]), 32'h22);
      chk("d20_word1", 32'(out20_log[1]), 32'h23);
      chk("d20_word2", 32'(out20_log[2]), 32'h10);
    end
    chk("d20_cmd_ready", 32'(cmd_ready20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
